// File: rtl/systolic_pkg.sv
// Shared types, default widths and the MAC helper for the N x N systolic array.
// Contents: state_t (job FSM states), default parameter values, mac_step().
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_N      = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_K_W    = 8;

  // The MAC is evaluated at a fixed wide width and truncated by the caller.
  // Truncating the low ACC_W bits yields the modulo-2^ACC_W sum for any
  // DATA_W <= 32 and ACC_W <= 64.
  localparam int MAC_W    = 64;
  localparam int MAC_IN_W = 32;

  function automatic logic signed [MAC_W-1:0] mac_step(
    input logic signed [MAC_W-1:0]    acc,
    input logic signed [MAC_IN_W-1:0] a,
    input logic signed [MAC_IN_W-1:0] b
  );
    logic signed [MAC_W-1:0] prod;
    prod = MAC_W'(a) * MAC_W'(b);
    return acc + prod;
  endfunction

endpackage

// File: rtl/systolic_array_nxn_if.sv
// Operand/result bundle between fetch logic, the systolic array and write-back.
//   master: job control (start/k_len/accumulate), operand stream
//           (in_valid, a_col, b_row) and result acceptance (out_ready).
//   slave : in_ready, out_valid, c_flat (element (i,j) at i*N+j), busy.
interface systolic_array_nxn_if
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_W    = DEF_K_W
);
  logic                      start;
  logic [K_W-1:0]            k_len;
  logic                      accumulate;
  logic                      in_valid;
  logic                      in_ready;
  logic [N*DATA_W-1:0]       a_col;
  logic [N*DATA_W-1:0]       b_row;
  logic                      out_valid;
  logic                      out_ready;
  logic [N*N*ACC_W-1:0]      c_flat;
  logic                      busy;

  modport master (
    output start, k_len, accumulate, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, c_flat, busy
  );

  modport slave (
    input  start, k_len, accumulate, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, c_flat, busy
  );

endinterface

// File: rtl/systolic_pe.sv
// One output-stationary processing element.
// Ports: clk, reset (async, active-low), clr (zero the accumulator),
//   a_in/a_vld_in from the left, b_in/b_vld_in from above,
//   a_out/b_out (+tags) registered pass-through, acc the running sum.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_vld_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     b_vld_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_vld_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     b_vld_out,
  output logic signed [ACC_W-1:0]  acc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
      if (clr) begin
        acc <= '0;
      end else if (a_vld_in && b_vld_in) begin
        acc <= ACC_W'(mac_step(MAC_W'(acc), MAC_IN_W'(a_in), MAC_IN_W'(b_in)));
      end
    end
  end

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary signed MAC array computing C = A*B over a streamed
// inner dimension. Ports: clk, reset (async, active-low), bus (slave side of
// systolic_array_nxn_if).
//
// state | meaning
// IDLE  | waiting for start; start with k_len=0 goes straight to DONE
// LOAD  | in_ready=1, one operand slice per in_valid beat
// FLUSH | 2N-1 cycles for the last skewed slice to reach PE (N-1,N-1)
// DONE  | out_valid=1, C held until out_ready
module systolic_array_nxn
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_W    = DEF_K_W
) (
  input logic               clk,
  input logic               reset,
  systolic_array_nxn_if.slave bus
);

  localparam int FL_W = $clog2(2 * N);

  state_t            state_q, state_d;
  logic [K_W-1:0]    beat_cnt;
  logic [FL_W-1:0]   flush_cnt;
  logic              beat;
  logic              accept;
  logic              clr;

  assign beat   = bus.in_valid && (state_q == LOAD);
  assign accept = (state_q == IDLE) && bus.start;
  // Clearing on the accept edge guarantees the first beat sees a zero sum.
  assign clr    = accept && !bus.accumulate;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.k_len == '0) ? DONE : LOAD;
      LOAD:    if (beat && beat_cnt == K_W'(1)) state_d = FLUSH;
      FLUSH:   if (flush_cnt == '0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == LOAD);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
  end

  // Flush count is loaded with 2N-2 and DONE is entered on the edge after it
  // reaches zero, giving exactly 2N-1 cycles after the last accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept)    beat_cnt <= bus.k_len;
      else if (beat) beat_cnt <= beat_cnt - K_W'(1);
      if (state_q == LOAD && state_d == FLUSH)
        flush_cnt <= FL_W'(2 * N - 2);
      else if (state_q == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FL_W'(1);
    end
  end

  // Grid wiring: the extra column of a_h and row of b_v catch the outputs of
  // the boundary PEs and are intentionally left unread.
  logic signed [DATA_W-1:0] a_h  [N][N+1];
  logic                     a_hv [N][N+1];
  logic signed [DATA_W-1:0] b_v  [N+1][N];
  logic                     b_vv [N+1][N];
  logic signed [ACC_W-1:0]  acc_a [N][N];

  // Lane g is delayed by g registers so that A row i and B column j meet in
  // PE (i,j) on the same cycle. The beat flag travels with the data as a tag.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DATA_W:0] a_lane, b_lane, a_edge, b_edge;
    assign a_lane = {beat, bus.a_col[gi*DATA_W +: DATA_W]};
    assign b_lane = {beat, bus.b_row[gi*DATA_W +: DATA_W]};

    if (gi == 0) begin : g_direct
      assign a_edge = a_lane;
      assign b_edge = b_lane;
    end else begin : g_delay
      logic [DATA_W:0] a_sr [gi];
      logic [DATA_W:0] b_sr [gi];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < gi; k++) begin
            a_sr[k] <= '0;
            b_sr[k] <= '0;
          end
        end else begin
          a_sr[0] <= a_lane;
          b_sr[0] <= b_lane;
          for (int k = 1; k < gi; k++) begin
            a_sr[k] <= a_sr[k-1];
            b_sr[k] <= b_sr[k-1];
          end
        end
      end
      assign a_edge = a_sr[gi-1];
      assign b_edge = b_sr[gi-1];
    end

    assign a_h[gi][0]  = a_edge[DATA_W-1:0];
    assign a_hv[gi][0] = a_edge[DATA_W];
    assign b_v[0][gi]  = b_edge[DATA_W-1:0];
    assign b_vv[0][gi] = b_edge[DATA_W];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .a_in      (a_h[gi][gj]),
        .a_vld_in  (a_hv[gi][gj]),
        .b_in      (b_v[gi][gj]),
        .b_vld_in  (b_vv[gi][gj]),
        .a_out     (a_h[gi][gj+1]),
        .a_vld_out (a_hv[gi][gj+1]),
        .b_out     (b_v[gi+1][gj]),
        .b_vld_out (b_vv[gi+1][gj]),
        .acc       (acc_a[gi][gj])
      );
    end
  end

  always_comb begin
    bus.c_flat = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.c_flat[(i*N+j)*ACC_W +: ACC_W] = acc_a[i][j];
  end

endmodule
